mc_control_unit: RTL and testbench

Parametrised second-generation multicycle control FSM for the RV32I core. It adds a memory-ready handshake on fetch and data access, a bounded wait timeout, and full branch evaluation including BLTU/BGEU. Illegal instructions and memory timeouts raise a trap, and an optional multi-cycle MUL/DIV execute state can be compiled in. It sits between the instruction register/ALU flags and the datapath muxes, register file and memory ports.

---
 rtl/mc_ctrl_pkg.sv | 67 ++++++
 rtl/mc_control_unit_branch_eval.sv | 29 ++
 rtl/mc_control_unit.sv | 218 +++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle RV32I control unit.
// Holds FSM state encodings, RV32I opcode and branch funct3 codes, trap cause
// codes and the packed control-strobe bundle driven by mc_control_unit.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned CAUSE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_ME   = 3'd3,
        ST_WB   = 3'd4,
        ST_MX   = 3'd5,
        ST_TRAP = 3'd6
    } state_e;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 2'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT = 2'd2;

    // Datapath/memory strobes produced each cycle by the control FSM.
    typedef struct packed {
        logic imem_req;
        logic ir_write;
        logic alu_sel_a;
        logic alu_sel_b;
        logic pc_write;
        logic pc_src;
        logic reg_write_enable;
        logic mem_read_enable;
        logic mem_write_enable;
        logic mem_to_reg;
        logic mul_start;
        logic mdu_sel;
    } ctrl_t;

    // True for the RV32I base opcodes this core executes.
    function automatic logic opc_known(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: opc_known = 1'b1;
            default:                                opc_known = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_unit_branch_eval.sv
// mc_branch_eval: combinational branch condition evaluation.
// Ports: funct3 (branch kind), zero/sign/carry ALU flags in;
//        taken_c (condition true), illegal_c (funct3 010/011) out.
module mc_branch_eval
    import mc_ctrl_pkg::*;
(
    input  logic [F3_W-1:0] funct3,
    input  logic            zero_flag,
    input  logic            sign_flag,
    input  logic            carry_flag,
    output logic            taken_c,
    output logic            illegal_c
);

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (funct3)
            F3_BEQ:  taken_c   = zero_flag;
            F3_BNE:  taken_c   = ~zero_flag;
            F3_BLT:  taken_c   = sign_flag;
            F3_BGE:  taken_c   = ~sign_flag;
            F3_BLTU: taken_c   = carry_flag;
            F3_BGEU: taken_c   = ~carry_flag;
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle RV32I control FSM with memory-ready handshake,
// bounded memory wait timeout, trap handling and optional MUL/DIV state.
// Params: MEM_TIMEOUT (max IF/ME wait cycles, 0 = unbounded),
//         TRAP_HALT (1 = TRAP is terminal until reset).
// Build option: define MC_CTRL_MULDIV_EN to enable the MX (MUL/DIV) state.
// Ports: clk, resetn (async active-low); IR fields opcode/funct3/funct7_b0;
//        ALU flags zero/sign/carry; mem_ready, mul_done handshakes;
//        state, datapath strobes, branch_taken, trap, trap_cause outputs.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TRAP_HALT   = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [F3_W-1:0]    funct3,
    input  logic               funct7_b0,
    input  logic               zero_flag,
    input  logic               sign_flag,
    input  logic               carry_flag,
    input  logic               mem_ready,
    input  logic               mul_done,
    output logic [STATE_W-1:0] state,
    output logic               imem_req,
    output logic               ir_write,
    output logic               alu_sel_a,
    output logic               alu_sel_b,
    output logic               pc_write,
    output logic               pc_src,
    output logic               reg_write_enable,
    output logic               mem_read_enable,
    output logic               mem_write_enable,
    output logic               mem_to_reg,
    output logic               mul_start,
    output logic               mdu_sel,
    output logic               branch_taken,
    output logic               trap,
    output logic [CAUSE_W-1:0] trap_cause
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    // Count value seen in the last allowed wait cycle; expiry happens there.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic                 branch_taken_q, branch_taken_d;
    logic [CAUSE_W-1:0]   trap_cause_q, trap_cause_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    ctrl_t                ctrl_c;
    ctrl_t                ctrl_out;

    logic is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
    logic br_taken_c, br_illegal_c;
    logic mdu_op, mdu_illegal, illegal_c, wait_expire_c;

    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_op     = (opcode == OPC_OP);

`ifdef MC_CTRL_MULDIV_EN
    assign mdu_op      = is_op & funct7_b0;
    assign mdu_illegal = 1'b0;
`else
    logic unused_mul_done;
    assign mdu_op          = 1'b0;
    assign mdu_illegal     = is_op & funct7_b0;
    assign unused_mul_done = mul_done;
`endif

    mc_branch_eval u_branch_eval (
        .funct3     (funct3),
        .zero_flag  (zero_flag),
        .sign_flag  (sign_flag),
        .carry_flag (carry_flag),
        .taken_c    (br_taken_c),
        .illegal_c  (br_illegal_c)
    );

    assign illegal_c     = ~opc_known(opcode) | (is_branch & br_illegal_c) | mdu_illegal;
    assign wait_expire_c = (MEM_TIMEOUT != 0) && (wait_cnt_q == CNT_LAST);

    // State, branch decision, trap cause and wait counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IF;
            branch_taken_q <= 1'b0;
            trap_cause_q   <= CAUSE_NONE;
            wait_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            branch_taken_q <= branch_taken_d;
            trap_cause_q   <= trap_cause_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d        = state_q;
        branch_taken_d = branch_taken_q;
        trap_cause_d   = trap_cause_q;
        ctrl_c         = '0;

        case (state_q)
            ST_IF: begin
                ctrl_c.imem_req = 1'b1;
                if (mem_ready) begin
                    ctrl_c.ir_write = 1'b1;
                    trap_cause_d    = CAUSE_NONE;
                    state_d         = ST_ID;
                end else if (wait_expire_c) begin
                    trap_cause_d = CAUSE_TIMEOUT;
                    state_d      = ST_TRAP;
                end
            end
            ST_ID: begin
                if (illegal_c) begin
                    trap_cause_d = CAUSE_ILLEGAL;
                    state_d      = ST_TRAP;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                ctrl_c.alu_sel_a = is_jal | is_auipc | is_branch;
                ctrl_c.alu_sel_b = is_opimm | is_load | is_store | is_auipc
                                 | is_jal | is_jalr | is_branch;
                branch_taken_d   = is_jal | is_jalr | (is_branch & br_taken_c);
                if (is_load | is_store) begin
                    state_d = ST_ME;
                end else if (mdu_op) begin
                    ctrl_c.mul_start = 1'b1;
                    state_d          = ST_MX;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_ME: begin
                ctrl_c.mem_read_enable  = is_load;
                ctrl_c.mem_write_enable = is_store;
                if (mem_ready) begin
                    if (is_load) begin
                        state_d = ST_WB;
                    end else begin
                        // Store completes here, so this is its PC update cycle.
                        ctrl_c.pc_write = 1'b1;
                        ctrl_c.pc_src   = branch_taken_q;
                        state_d         = ST_IF;
                    end
                end else if (wait_expire_c) begin
                    trap_cause_d = CAUSE_TIMEOUT;
                    state_d      = ST_TRAP;
                end
            end
            ST_WB: begin
                ctrl_c.reg_write_enable = ~is_branch;
                ctrl_c.mem_to_reg       = is_load;
                ctrl_c.mdu_sel          = mdu_op;
                ctrl_c.pc_write         = 1'b1;
                ctrl_c.pc_src           = branch_taken_q;
                state_d                 = ST_IF;
            end
            ST_MX: begin
`ifdef MC_CTRL_MULDIV_EN
                if (mul_done) begin
                    state_d = ST_WB;
                end
`else
                state_d = ST_IF;
`endif
            end
            ST_TRAP: begin
                if (TRAP_HALT == 0) begin
                    state_d = ST_IF;
                end
            end
            default: state_d = ST_IF;
        endcase

        // Wait counter only runs while stalled on memory in the same state.
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if ((state_q == ST_IF || state_q == ST_ME) && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Everything is forced low while reset is held, so an aborted access
    // cannot leave a strobe asserted.
    assign ctrl_out         = resetn ? ctrl_c : '0;
    assign imem_req         = ctrl_out.imem_req;
    assign ir_write         = ctrl_out.ir_write;
    assign alu_sel_a        = ctrl_out.alu_sel_a;
    assign alu_sel_b        = ctrl_out.alu_sel_b;
    assign pc_write         = ctrl_out.pc_write;
    assign pc_src           = ctrl_out.pc_src;
    assign reg_write_enable = ctrl_out.reg_write_enable;
    assign mem_read_enable  = ctrl_out.mem_read_enable;
    assign mem_write_enable = ctrl_out.mem_write_enable;
    assign mem_to_reg       = ctrl_out.mem_to_reg;
    assign mul_start        = ctrl_out.mul_start;
    assign mdu_sel          = ctrl_out.mdu_sel;

    assign state        = resetn ? state_q : ST_IF;
    assign branch_taken = resetn & branch_taken_q;
    assign trap         = resetn & (state_q == ST_TRAP);
    assign trap_cause   = resetn ? trap_cause_q : CAUSE_NONE;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: randomized self-checking bench for mc_control_unit.
// Each instruction is turned into an expected per-cycle trace built from the
// phase rules (fetch waits, decode, execute, memory waits, MUL/DIV, writeback,
// trap) and the DUT is compared against it cycle by cycle.
module tb_mc_control_unit;

    localparam int unsigned MEM_TO = 4;

`ifdef MC_CTRL_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    localparam logic [6:0] O_LUI = 7'h37, O_AUIPC = 7'h17, O_JAL = 7'h6F, O_JALR = 7'h67;
    localparam logic [6:0] O_BR = 7'h63, O_LD = 7'h03, O_ST = 7'h23, O_OPI = 7'h13, O_OP = 7'h33;

    typedef struct packed {
        logic [2:0] st;
        logic imem_req, ir_write, alu_sel_a, alu_sel_b, pc_write, pc_src;
        logic reg_we, mem_rd, mem_wr, mem_to_reg, mul_start, mdu_sel, trap;
        logic [1:0] cause;
        logic br;
    } cyc_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b0, zero_flag, sign_flag, carry_flag, mem_ready, mul_done;
    logic [2:0] state;
    logic       imem_req, ir_write, alu_sel_a, alu_sel_b, pc_write, pc_src;
    logic       reg_write_enable, mem_read_enable, mem_write_enable, mem_to_reg;
    logic       mul_start, mdu_sel, branch_taken, trap;
    logic [1:0] trap_cause;

    int n_tests = 0;
    int n_fail  = 0;
    int n_instr = 0;

    logic       m_br;
    logic [1:0] m_cause;
    cyc_t       q_exp[$];
    logic       q_mr[$];
    logic       q_md[$];

    always #5 clk = ~clk;

    mc_control_unit #(.MEM_TIMEOUT(MEM_TO), .TRAP_HALT(1)) dut (
        .clk(clk), .resetn(resetn), .opcode(opcode), .funct3(funct3), .funct7_b0(funct7_b0),
        .zero_flag(zero_flag), .sign_flag(sign_flag), .carry_flag(carry_flag),
        .mem_ready(mem_ready), .mul_done(mul_done), .state(state), .imem_req(imem_req),
        .ir_write(ir_write), .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write_enable(reg_write_enable), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .mem_to_reg(mem_to_reg), .mul_start(mul_start),
        .mdu_sel(mdu_sel), .branch_taken(branch_taken), .trap(trap), .trap_cause(trap_cause)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic cyc_t sample();
        sample            = '0;
        sample.st         = state;
        sample.imem_req   = imem_req;
        sample.ir_write   = ir_write;
        sample.alu_sel_a  = alu_sel_a;
        sample.alu_sel_b  = alu_sel_b;
        sample.pc_write   = pc_write;
        sample.pc_src     = pc_src;
        sample.reg_we     = reg_write_enable;
        sample.mem_rd     = mem_read_enable;
        sample.mem_wr     = mem_write_enable;
        sample.mem_to_reg = mem_to_reg;
        sample.mul_start  = mul_start;
        sample.mdu_sel    = mdu_sel;
        sample.trap       = trap;
        sample.cause      = trap_cause;
        sample.br         = branch_taken;
    endfunction

    // Operand selects matter in EX, writeback selects in WB, pc_src with pc_write.
    function automatic cyc_t mask(input cyc_t v, input cyc_t ref_c);
        mask = v;
        if (ref_c.st != 3'd2) begin
            mask.alu_sel_a = 1'b0;
            mask.alu_sel_b = 1'b0;
        end
        if (ref_c.st != 3'd4) begin
            mask.mem_to_reg = 1'b0;
            mask.mdu_sel    = 1'b0;
        end
        if (!ref_c.pc_write) mask.pc_src = 1'b0;
    endfunction

    function automatic cyc_t base(input logic [2:0] st);
        base       = '0;
        base.st    = st;
        base.br    = m_br;
        base.cause = m_cause;
        base.trap  = (st == 3'd6);
    endfunction

    function automatic void add(input cyc_t c, input logic mr, input logic md);
        q_exp.push_back(c);
        q_mr.push_back(mr);
        q_md.push_back(md);
    endfunction

    function automatic logic known(input logic [6:0] o);
        return (o == O_LUI) || (o == O_AUIPC) || (o == O_JAL) || (o == O_JALR) || (o == O_BR)
            || (o == O_LD) || (o == O_ST) || (o == O_OPI) || (o == O_OP);
    endfunction

    function automatic logic br_cond(input logic [2:0] f3, input logic [2:0] fl);
        case (f3)
            3'd0: return fl[0];
            3'd1: return !fl[0];
            3'd4: return fl[1];
            3'd5: return !fl[1];
            3'd6: return fl[2];
            3'd7: return !fl[2];
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_reset();
        cyc_t        obs;
        logic [18:0] ov;
        resetn    = 1'b0;
        mem_ready = rbit();
        mul_done  = rbit();
        #1;
        obs = sample();
        ov  = obs;
        check("reset_outputs", 32'(ov), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn    = 1'b1;
        mem_ready = 1'b0;
        mul_done  = 1'b0;
        m_br      = 1'b0;
        m_cause   = 2'd0;
    endtask

    // fw/mw: wait cycles before mem_ready in IF/ME (>= MEM_TO means never);
    // md: MX cycles until mul_done; cut: cycle index at which reset hits (-1 none).
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input logic [2:0] fl, input int fw, input int mw, input int md,
                             input int cut);
        cyc_t        c, obs;
        logic [18:0] ov, ev;
        logic        legal, is_br, is_ld, is_st, is_mdu, tk, to_trap;
        q_exp.delete(); q_mr.delete(); q_md.delete();
        n_instr++;
        opcode = opc; funct3 = f3; funct7_b0 = f7;
        zero_flag = fl[0]; sign_flag = fl[1]; carry_flag = fl[2];

        is_br   = (opc == O_BR);
        is_ld   = (opc == O_LD);
        is_st   = (opc == O_ST);
        is_mdu  = (opc == O_OP) && f7 && MULDIV;
        legal   = known(opc) && !(is_br && (f3 == 3'd2 || f3 == 3'd3))
                  && !((opc == O_OP) && f7 && !MULDIV);
        tk      = (opc == O_JAL) || (opc == O_JALR) || (is_br && br_cond(f3, fl));
        to_trap = 1'b0;

        for (int k = 0; k < fw && k < int'(MEM_TO); k++) begin
            c = base(3'd0); c.imem_req = 1'b1; add(c, 1'b0, rbit());
        end
        if (fw >= int'(MEM_TO)) begin
            m_cause = 2'd2; to_trap = 1'b1;
        end else begin
            c = base(3'd0); c.imem_req = 1'b1; c.ir_write = 1'b1; add(c, 1'b1, rbit());
            add(base(3'd1), rbit(), rbit());
            if (!legal) begin
                m_cause = 2'd1; to_trap = 1'b1;
            end else begin
                c = base(3'd2);
                c.alu_sel_a = (opc == O_JAL) || (opc == O_AUIPC) || is_br;
                c.alu_sel_b = (opc == O_OPI) || is_ld || is_st || (opc == O_AUIPC)
                              || (opc == O_JAL) || (opc == O_JALR) || is_br;
                c.mul_start = is_mdu;
                add(c, rbit(), rbit());
                m_br = tk;
                if (is_ld || is_st) begin
                    for (int k = 0; k < mw && k < int'(MEM_TO); k++) begin
                        c = base(3'd3); c.mem_rd = is_ld; c.mem_wr = is_st; add(c, 1'b0, rbit());
                    end
                    if (mw >= int'(MEM_TO)) begin
                        m_cause = 2'd2; to_trap = 1'b1;
                    end else begin
                        c = base(3'd3); c.mem_rd = is_ld; c.mem_wr = is_st;
                        if (is_st) begin c.pc_write = 1'b1; c.pc_src = m_br; end
                        add(c, 1'b1, rbit());
                    end
                end else if (is_mdu) begin
                    for (int k = 0; k < md; k++) add(base(3'd5), 1'b0, (k == md - 1));
                end
                if (!to_trap && !is_st) begin
                    c = base(3'd4);
                    c.reg_we = !is_br; c.mem_to_reg = is_ld; c.mdu_sel = is_mdu;
                    c.pc_write = 1'b1; c.pc_src = m_br;
                    add(c, rbit(), 1'b0);
                end
            end
        end
        if (to_trap) for (int k = 0; k < 3; k++) add(base(3'd6), rbit(), rbit());

        for (int i = 0; i < q_exp.size(); i++) begin
            if (i == cut) begin
                do_reset();
                return;
            end
            mem_ready = q_mr[i];
            mul_done  = q_md[i];
            #1;
            obs = sample();
            ov  = mask(obs, q_exp[i]);
            ev  = mask(q_exp[i], q_exp[i]);
            check($sformatf("cyc_i%0d_c%0d", n_instr, i), 32'(ov), 32'(ev));
            @(negedge clk);
        end
        if (to_trap) do_reset();
    endtask

    function automatic logic [6:0] pick_opc(input int unsigned sel);
        case (sel)
            0: return O_LUI;
            1: return O_AUIPC;
            2: return O_JAL;
            3: return O_JALR;
            4: return O_BR;
            5: return O_LD;
            6: return O_ST;
            7: return O_OPI;
            8: return O_OP;
            default: begin
                case ($urandom_range(0, 3))
                    0: return 7'h7F;
                    1: return 7'h0F;
                    2: return 7'h73;
                    default: return 7'h00;
                endcase
            end
        endcase
    endfunction

    task automatic random_instr();
        logic [6:0] opc;
        int fw, mw, md, cut;
        opc = pick_opc($urandom_range(0, 9));
        fw  = ($urandom_range(0, 15) == 0) ? int'(MEM_TO) : int'($urandom_range(0, 3));
        mw  = ($urandom_range(0, 15) == 0) ? int'(MEM_TO) : int'($urandom_range(0, 3));
        md  = int'($urandom_range(1, 7));
        cut = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 6)) : -1;
        run_instr(opc, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                  3'($urandom_range(0, 7)), fw, mw, md, cut);
    endtask

    initial begin
        resetn = 1'b0; opcode = '0; funct3 = '0; funct7_b0 = 1'b0;
        zero_flag = 1'b0; sign_flag = 1'b0; carry_flag = 1'b0;
        mem_ready = 1'b0; mul_done = 1'b0;
        m_br = 1'b0; m_cause = 2'd0;
        @(negedge clk);
        do_reset();

        run_instr(O_OPI, 3'd0, 1'b0, 3'b000, 0, 0, 1, -1);   // ADDI, no waits
        run_instr(O_BR,  3'd6, 1'b0, 3'b100, 0, 0, 1, -1);   // BLTU, carry set: taken
        run_instr(O_BR,  3'd7, 1'b0, 3'b100, 0, 0, 1, -1);   // BGEU, carry set: not taken
        run_instr(O_JAL, 3'd0, 1'b0, 3'b000, 3, 0, 1, -1);   // ready on last allowed IF cycle
        run_instr(O_LD,  3'd2, 1'b0, 3'b000, 0, 3, 1, -1);   // LOAD with 3 ME waits
        run_instr(O_ST,  3'd2, 1'b0, 3'b000, 1, 0, 1, -1);   // STORE
        run_instr(O_OPI, 3'd0, 1'b0, 3'b000, 4, 0, 1, -1);   // fetch timeout
        run_instr(7'h7F, 3'd0, 1'b0, 3'b000, 0, 0, 1, -1);   // illegal opcode
        run_instr(O_BR,  3'd2, 1'b0, 3'b000, 0, 0, 1, -1);   // illegal branch funct3
        run_instr(O_ST,  3'd2, 1'b0, 3'b000, 0, 4, 1, -1);   // store timeout in ME
        run_instr(O_OP,  3'd0, 1'b1, 3'b000, 0, 0, 5, -1);   // MUL, done after 5 MX cycles
        run_instr(O_ST,  3'd2, 1'b0, 3'b000, 0, 3, 1, 4);    // reset mid-ME store

        for (int n = 0; n < 300; n++) random_instr();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
